// File: rtl/bcd_counter_multi.sv
// Multi-digit cascaded BCD counter with up/down count, clear, validated
// parallel load and a combinational terminal-count strobe for chaining.
module bcd_counter_multi #(
   parameter int                  DIGITS = 4,
   parameter logic [4*DIGITS-1:0] INIT   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  load,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [4*DIGITS-1:0]   q_out,
   output logic                  carry_out,
   output logic                  load_err
);

   logic [4*DIGITS-1:0] cnt_q, cnt_d;
   logic                load_err_q, load_err_d;
   logic [3:0]          nib;
   logic                ripple;
   logic                all_nine, all_zero;

   // Next-state: clr > load > count > hold; ripple carries the "all lower
   // digits at terminal value" condition up the digit chain.
   always_comb begin
      cnt_d      = cnt_q;
      load_err_d = 1'b0;
      ripple     = 1'b1;
      nib        = 4'd0;
      if (clr) begin
         cnt_d = INIT;
      end else if (load) begin
         for (int k = 0; k < DIGITS; k++) begin
            nib = bcd_in[4*k +: 4];
            if (nib > 4'd9) begin
               cnt_d[4*k +: 4] = 4'd0;
               load_err_d      = 1'b1;
            end else begin
               cnt_d[4*k +: 4] = nib;
            end
         end
      end else if (en) begin
         for (int k = 0; k < DIGITS; k++) begin
            nib = cnt_q[4*k +: 4];
            if (up_dn) begin
               // a corrupted digit (10..15) behaves as 9: wraps and carries
               if (ripple)
                  cnt_d[4*k +: 4] = (nib >= 4'd9) ? 4'd0 : nib + 4'd1;
               ripple = ripple & (nib >= 4'd9);
            end else begin
               // a corrupted digit behaves as 9: decrements to 8, no borrow
               if (ripple)
                  cnt_d[4*k +: 4] = (nib == 4'd0) ? 4'd9 :
                                    (nib > 4'd9)  ? 4'd8 : nib - 4'd1;
               ripple = ripple & (nib == 4'd0);
            end
         end
      end
   end

   // State registers with asynchronous active-low reset to INIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= INIT;
         load_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         load_err_q <= load_err_d;
      end
   end

   // Terminal-count detection for the chaining strobe.
   always_comb begin
      all_nine  = (cnt_q == {DIGITS{4'h9}});
      all_zero  = (cnt_q == '0);
      carry_out = en & ~load & ~clr & (up_dn ? all_nine : all_zero);
   end

   assign q_out    = cnt_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboard bench for bcd_counter_multi: stimulus pushes expected results
// from an integer-valued reference model, a monitor pops and compares.
module tb_bcd_counter_multi;

   localparam int DIGITS = 4;
   localparam int W      = 4*DIGITS;
   localparam int MOD    = 10**DIGITS;

   logic          clk = 1'b0;
   logic          rst_n, clr, load, en, up_dn;
   logic [W-1:0]  bcd_in, q_out;
   logic          carry_out, load_err;

   bcd_counter_multi #(.DIGITS(DIGITS), .INIT('0)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .en(en),
      .up_dn(up_dn), .bcd_in(bcd_in), .q_out(q_out),
      .carry_out(carry_out), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic         err;
      logic         cy;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   mval  = 0;
   bit   merr  = 1'b0;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Drive one cycle of stimulus and record the model's expectation.
   task automatic cycle(input bit c, input bit l, input bit e, input bit u,
                        input logic [W-1:0] b);
      exp_t ent;
      int   pw;
      @(negedge clk);
      clr = c; load = l; en = e; up_dn = u; bcd_in = b;
      ent.cy = e & !l & !c & (u ? (mval == MOD-1) : (mval == 0));
      if (c) begin
         mval = 0; merr = 0;
      end else if (l) begin
         mval = 0; merr = 0; pw = 1;
         for (int k = 0; k < DIGITS; k++) begin
            if (b[4*k +: 4] > 4'd9) merr = 1;
            else mval += int'(b[4*k +: 4]) * pw;
            pw *= 10;
         end
      end else begin
         if (e) mval = u ? (mval + 1) % MOD : (mval + MOD - 1) % MOD;
         merr = 0;
      end
      ent.q   = to_bcd(mval);
      ent.err = merr;
      sbq.push_back(ent);
   endtask

   // Monitor: carry sampled after inputs settle, registers after the edge.
   initial begin
      exp_t e;
      logic cy_s;
      forever begin
         @(negedge clk);
         #2 cy_s = carry_out;
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            total++;
            if (cy_s !== e.cy) begin
               bad++;
               $display("FAIL carry_out: got %b want %b (t=%0t)", cy_s, e.cy, $time);
            end
            total++;
            if (q_out !== e.q) begin
               bad++;
               $display("FAIL q_out: got %h want %h (t=%0t)", q_out, e.q, $time);
            end
            total++;
            if (load_err !== e.err) begin
               bad++;
               $display("FAIL load_err: got %b want %b (t=%0t)", load_err, e.err, $time);
            end
         end
      end
   end

   task automatic check_now(input string name, input logic [W-1:0] got,
                            input logic [W-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   initial begin
      logic [W-1:0] b;
      rst_n = 1'b0; clr = 0; load = 0; en = 0; up_dn = 1; bcd_in = '0;
      #2;
      check_now("reset_q", q_out, '0);
      check_now("reset_err", W'(load_err), '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // asynchronous reset mid-count
      cycle(0, 1, 0, 1, 16'h0347);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_now("async_rst_q", q_out, '0);
      check_now("async_rst_err", W'(load_err), '0);
      @(negedge clk);
      clr = 0; load = 0; en = 0; up_dn = 1;
      rst_n = 1'b1; mval = 0; merr = 0;

      // up ripple
      cycle(0, 1, 0, 1, 16'h0998);
      repeat (3) cycle(0, 0, 1, 1, '0);
      // up wrap
      cycle(0, 1, 0, 1, 16'h9999);
      cycle(0, 0, 1, 1, '0);
      // down borrow and wrap
      cycle(0, 1, 0, 0, 16'h1000);
      cycle(0, 0, 1, 0, '0);
      cycle(0, 1, 0, 0, 16'h0000);
      cycle(0, 0, 1, 0, '0);
      // invalid load, then pulse clears on idle edge
      cycle(0, 1, 0, 1, 16'h3A7F);
      cycle(0, 0, 0, 1, '0);
      // priority
      cycle(0, 1, 0, 1, 16'h1234);
      cycle(1, 1, 1, 1, 16'h0042);
      cycle(0, 1, 1, 1, 16'h0042);
      cycle(0, 0, 0, 0, '0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < DIGITS; k++)
            b[4*k +: 4] = ($urandom % 4 == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
         if ($urandom % 4 == 0) b = ($urandom % 2) ? 16'h9998 : 16'h0001;
         cycle($urandom % 25 == 0, $urandom % 8 == 0, $urandom % 4 != 0,
               1'($urandom % 2), b);
      end

      repeat (3) @(posedge clk);
      #2;
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
